// File: rtl/ifu_fetch_unit_if.sv
// Fetch-unit bus: buffer pause and backend redirect, I-cache request/response,
// and the registered two-slot instruction bundle.
interface ifu_fetch_unit_if;
    logic        pause_i;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        icache_req_valid;
    logic [31:0] icache_req_addr;
    logic        icache_req_ready;
    logic        icache_resp_valid;
    logic [63:0] icache_resp_data;
    logic        inst0_valid;
    logic        inst1_valid;
    logic [31:0] inst0_pc;
    logic [31:0] inst1_pc;
    logic [31:0] inst0_word;
    logic [31:0] inst1_word;
    logic        inst0_isJ;
    logic        inst1_isJ;
    logic        inst0_isBr;
    logic        inst1_isBr;

    modport master (
        input  pause_i, redirect_valid, redirect_pc,
        input  icache_req_ready, icache_resp_valid, icache_resp_data,
        output icache_req_valid, icache_req_addr,
        output inst0_valid, inst1_valid, inst0_pc, inst1_pc,
        output inst0_word, inst1_word, inst0_isJ, inst1_isJ, inst0_isBr, inst1_isBr
    );

    modport slave (
        output pause_i, redirect_valid, redirect_pc,
        output icache_req_ready, icache_resp_valid, icache_resp_data,
        input  icache_req_valid, icache_req_addr,
        input  inst0_valid, inst1_valid, inst0_pc, inst1_pc,
        input  inst0_word, inst1_word, inst0_isJ, inst1_isJ, inst0_isBr, inst1_isBr
    );
endinterface

// File: rtl/ifu_fetch_unit.sv
// Sequential fetch front end: one outstanding 8-byte I-cache request, turning
// each returned line into a pre-decoded two-slot bundle; redirects squash stale lines.
module ifu_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input logic             clk,
    input logic             rst,
    ifu_fetch_unit_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DISCARD} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc;
    logic [31:0] line_base;
    logic        handshake;
    logic        take_line;

    function automatic logic pd_is_j(input logic [31:0] w);
        return (w[31:26] == 6'b000010) || (w[31:26] == 6'b000011) ||
               ((w[31:26] == 6'b000000) && ((w[5:0] == 6'b001000) || (w[5:0] == 6'b001001)));
    endfunction

    function automatic logic pd_is_br(input logic [31:0] w);
        return (w[31:28] == 4'b0001) ||
               ((w[31:26] == 6'b000001) && (w[19:17] == 3'b000) && (w[20] == 1'b0 || w[20] == 1'b1));
    endfunction

    assign line_base = {pc[31:3], 3'b000};
    assign handshake = (state == S_REQ) && !bus.pause_i && bus.icache_req_ready;
    // A response coinciding with a redirect is for the old path and is dropped.
    assign take_line = (state == S_WAIT) && bus.icache_resp_valid && !bus.redirect_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    state_nxt = S_REQ;
            S_REQ:     if (handshake) state_nxt = bus.redirect_valid ? S_DISCARD : S_WAIT;
            S_WAIT: begin
                if (bus.icache_resp_valid)   state_nxt = S_REQ;
                else if (bus.redirect_valid) state_nxt = S_DISCARD;
            end
            S_DISCARD: if (bus.icache_resp_valid) state_nxt = S_REQ;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.icache_req_valid = (state == S_REQ) && !bus.pause_i;
        bus.icache_req_addr  = (state == S_REQ) ? line_base : 32'h0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                    pc <= RESET_PC;
        else if (bus.redirect_valid) pc <= bus.redirect_pc;
        else if (take_line)          pc <= line_base + 32'd8;
    end

    // Bundle stage: valids pulse for one cycle, payload holds between lines.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.inst0_valid <= 1'b0;
            bus.inst1_valid <= 1'b0;
            bus.inst0_pc    <= 32'h0;
            bus.inst1_pc    <= 32'h0;
            bus.inst0_word  <= 32'h0;
            bus.inst1_word  <= 32'h0;
            bus.inst0_isJ   <= 1'b0;
            bus.inst1_isJ   <= 1'b0;
            bus.inst0_isBr  <= 1'b0;
            bus.inst1_isBr  <= 1'b0;
        end else begin
            bus.inst0_valid <= take_line && !pc[2];
            bus.inst1_valid <= take_line;
            if (take_line) begin
                bus.inst0_pc   <= line_base;
                bus.inst1_pc   <= line_base + 32'd4;
                bus.inst0_word <= bus.icache_resp_data[31:0];
                bus.inst1_word <= bus.icache_resp_data[63:32];
                bus.inst0_isJ  <= pd_is_j(bus.icache_resp_data[31:0]);
                bus.inst1_isJ  <= pd_is_j(bus.icache_resp_data[63:32]);
                bus.inst0_isBr <= pd_is_br(bus.icache_resp_data[31:0]);
                bus.inst1_isBr <= pd_is_br(bus.icache_resp_data[63:32]);
            end
        end
    end

    resp_without_request: assert property (@(posedge clk) disable iff (!rst)
        !(bus.icache_resp_valid && (state == S_IDLE || state == S_REQ)));
endmodule

// File: tb/tb_ifu_fetch_unit.sv
// Directed bench for ifu_fetch_unit: a transaction-level fetch model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_ifu_fetch_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ifu_fetch_unit_if bus();
    ifu_fetch_unit #(.RESET_PC(32'hBFC0_0000)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic ref_is_j(input logic [31:0] w);
        case (w[31:26])
            6'd2, 6'd3: return 1'b1;
            6'd0:       return (w[5:0] == 6'd8) || (w[5:0] == 6'd9);
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic ref_is_br(input logic [31:0] w);
        case (w[31:26])
            6'd4, 6'd5, 6'd6, 6'd7: return 1'b1;
            6'd1: return (w[20:16] == 5'd0) || (w[20:16] == 5'd1) ||
                         (w[20:16] == 5'd16) || (w[20:16] == 5'd17);
            default: return 1'b0;
        endcase
    endfunction

    // Model: fetch has started, a request is outstanding, that request is stale.
    logic        m_started, m_busy, m_stale;
    logic [31:0] m_pc;
    logic        e_v0, e_v1, e_j0, e_j1, e_b0, e_b1;
    logic [31:0] e_pc0, e_pc1, e_w0, e_w1;

    always @(negedge clk) begin
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic [31:0] base;
        if (!rst) begin
            m_started = 1'b0; m_busy = 1'b0; m_stale = 1'b0; m_pc = 32'hBFC0_0000;
            e_v0 = 1'b0; e_v1 = 1'b0; e_j0 = 1'b0; e_j1 = 1'b0; e_b0 = 1'b0; e_b1 = 1'b0;
            e_pc0 = 32'h0; e_pc1 = 32'h0; e_w0 = 32'h0; e_w1 = 32'h0;
        end
        exp_rv   = m_started && !m_busy && !bus.pause_i;
        exp_addr = (m_started && !m_busy) ? {m_pc[31:3], 3'b000} : 32'h0;
        chk1 ("req_valid", bus.icache_req_valid, exp_rv);
        chk32("req_addr",  bus.icache_req_addr,  exp_addr);
        chk1 ("inst0_valid", bus.inst0_valid, e_v0);
        chk1 ("inst1_valid", bus.inst1_valid, e_v1);
        chk32("inst0_pc",    bus.inst0_pc,    e_pc0);
        chk32("inst1_pc",    bus.inst1_pc,    e_pc1);
        chk32("inst0_word",  bus.inst0_word,  e_w0);
        chk32("inst1_word",  bus.inst1_word,  e_w1);
        chk1 ("inst0_isJ",   bus.inst0_isJ,   e_j0);
        chk1 ("inst1_isJ",   bus.inst1_isJ,   e_j1);
        chk1 ("inst0_isBr",  bus.inst0_isBr,  e_b0);
        chk1 ("inst1_isBr",  bus.inst1_isBr,  e_b1);
        if (rst) begin
            base = {m_pc[31:3], 3'b000};
            e_v0 = 1'b0;
            e_v1 = 1'b0;
            if (!m_started) begin
                m_started = 1'b1;
                if (bus.redirect_valid) m_pc = bus.redirect_pc;
            end else if (!m_busy) begin
                if (exp_rv && bus.icache_req_ready) begin
                    m_busy  = 1'b1;
                    m_stale = bus.redirect_valid;
                end
                if (bus.redirect_valid) m_pc = bus.redirect_pc;
            end else if (bus.icache_resp_valid) begin
                m_busy = 1'b0;
                if (bus.redirect_valid) m_pc = bus.redirect_pc;
                else if (!m_stale) begin
                    e_v0  = (m_pc[2] == 1'b0);
                    e_v1  = 1'b1;
                    e_pc0 = base;
                    e_pc1 = base + 32'd4;
                    e_w0  = bus.icache_resp_data[31:0];
                    e_w1  = bus.icache_resp_data[63:32];
                    e_j0  = ref_is_j(e_w0);
                    e_j1  = ref_is_j(e_w1);
                    e_b0  = ref_is_br(e_w0);
                    e_b1  = ref_is_br(e_w1);
                    m_pc  = base + 32'd8;
                end
            end else if (bus.redirect_valid) begin
                m_stale = 1'b1;
                m_pc    = bus.redirect_pc;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Called in REQ with pause low: handshake, then a one-cycle response.
    task automatic fetch(input logic [63:0] line);
        bus.icache_req_ready = 1'b1;
        cyc();
        bus.icache_req_ready  = 1'b0;
        bus.icache_resp_valid = 1'b1;
        bus.icache_resp_data  = line;
        cyc();
        bus.icache_resp_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        bus.pause_i = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.icache_req_ready = 1'b0;
        bus.icache_resp_valid = 1'b0;
        bus.icache_resp_data = 64'h0;
        repeat (2) cyc();
        chk1 ("rst_req_valid", bus.icache_req_valid, 1'b0);
        chk32("rst_req_addr",  bus.icache_req_addr,  32'h0);
        chk32("rst_inst1_pc",  bus.inst1_pc,         32'h0);

        rst = 1'b1;
        cyc();
        chk1 ("first_req_valid", bus.icache_req_valid, 1'b1);
        chk32("first_req_addr",  bus.icache_req_addr,  32'hBFC0_0000);
        fetch(64'h2402_0001_2401_0000);
        chk1 ("b1_inst0_valid", bus.inst0_valid, 1'b1);
        chk32("b1_inst0_pc",    bus.inst0_pc,    32'hBFC0_0000);
        chk32("b1_inst0_word",  bus.inst0_word,  32'h2401_0000);
        chk1 ("b1_inst1_valid", bus.inst1_valid, 1'b1);
        chk32("b1_inst1_pc",    bus.inst1_pc,    32'hBFC0_0004);
        chk32("b1_inst1_word",  bus.inst1_word,  32'h2402_0001);
        chk32("b1_next_addr",   bus.icache_req_addr, 32'hBFC0_0008);

        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0004;
        cyc();
        bus.redirect_valid = 1'b0;
        chk32("redir_addr", bus.icache_req_addr, 32'h8000_0000);
        chk1 ("redir_inst1_cleared", bus.inst1_valid, 1'b0);
        fetch(64'h2403_0002_FFFF_FFFF);
        chk1 ("odd_inst0_valid", bus.inst0_valid, 1'b0);
        chk1 ("odd_inst1_valid", bus.inst1_valid, 1'b1);
        chk32("odd_inst1_pc",    bus.inst1_pc,    32'h8000_0004);
        chk32("odd_next_addr",   bus.icache_req_addr, 32'h8000_0008);

        fetch(64'h1022_0003_0810_0000);
        chk32("jb_inst0_pc", bus.inst0_pc,   32'h8000_0008);
        chk1 ("j_inst0_isJ",  bus.inst0_isJ,  1'b1);
        chk1 ("j_inst0_isBr", bus.inst0_isBr, 1'b0);
        chk1 ("beq_inst1_isJ",  bus.inst1_isJ,  1'b0);
        chk1 ("beq_inst1_isBr", bus.inst1_isBr, 1'b1);
        fetch(64'h0441_0002_03E0_0008);
        chk1 ("jr_inst0_isJ",    bus.inst0_isJ,  1'b1);
        chk1 ("jr_inst0_isBr",   bus.inst0_isBr, 1'b0);
        chk1 ("bgez_inst1_isBr", bus.inst1_isBr, 1'b1);

        // Redirect while the request is in flight: its line must be dropped.
        bus.icache_req_ready = 1'b1;
        cyc();
        bus.icache_req_ready = 1'b0;
        bus.redirect_valid   = 1'b1;
        bus.redirect_pc      = 32'h8000_0100;
        cyc();
        bus.redirect_valid = 1'b0;
        cyc();
        bus.icache_resp_valid = 1'b1;
        bus.icache_resp_data  = 64'hDEAD_BEEF_DEAD_BEEF;
        cyc();
        bus.icache_resp_valid = 1'b0;
        chk1 ("stale_inst0_valid", bus.inst0_valid, 1'b0);
        chk1 ("stale_inst1_valid", bus.inst1_valid, 1'b0);
        chk32("stale_word_held",   bus.inst1_word,  32'h0441_0002);
        chk1 ("stale_req_valid",   bus.icache_req_valid, 1'b1);
        chk32("stale_next_addr",   bus.icache_req_addr,  32'h8000_0100);

        bus.pause_i = 1'b1;
        bus.icache_req_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk1 ("pause_req_valid", bus.icache_req_valid, 1'b0);
            chk32("pause_req_addr",  bus.icache_req_addr,  32'h8000_0100);
        end
        bus.pause_i = 1'b0;
        cyc();
        bus.icache_req_ready  = 1'b0;
        bus.pause_i           = 1'b1;
        bus.icache_resp_valid = 1'b1;
        bus.icache_resp_data  = 64'hAAAA_5555_0C00_0040;
        cyc();
        bus.icache_resp_valid = 1'b0;
        chk1 ("pwait_inst0_valid", bus.inst0_valid, 1'b1);
        chk1 ("pwait_inst1_valid", bus.inst1_valid, 1'b1);
        chk32("pwait_inst0_pc",    bus.inst0_pc,    32'h8000_0100);
        chk1 ("jal_inst0_isJ",     bus.inst0_isJ,   1'b1);
        chk1 ("pwait_req_valid",   bus.icache_req_valid, 1'b0);
        chk32("pwait_next_addr",   bus.icache_req_addr,  32'h8000_0108);
        bus.pause_i = 1'b0;

        // Redirect landing on the same cycle as the response.
        bus.icache_req_ready = 1'b1;
        cyc();
        bus.icache_req_ready  = 1'b0;
        bus.icache_resp_valid = 1'b1;
        bus.icache_resp_data  = 64'h0000_0001_0000_0001;
        bus.redirect_valid    = 1'b1;
        bus.redirect_pc       = 32'h8000_0200;
        cyc();
        bus.icache_resp_valid = 1'b0;
        bus.redirect_valid    = 1'b0;
        chk1 ("rr_inst0_valid", bus.inst0_valid, 1'b0);
        chk1 ("rr_inst1_valid", bus.inst1_valid, 1'b0);
        chk1 ("rr_req_valid",   bus.icache_req_valid, 1'b1);
        chk32("rr_req_addr",    bus.icache_req_addr,  32'h8000_0200);

        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFF8;
        cyc();
        bus.redirect_valid = 1'b0;
        fetch(64'h0000_0000_1000_FFFF);
        chk32("wrap_inst0_pc",   bus.inst0_pc,   32'hFFFF_FFF8);
        chk32("wrap_inst1_pc",   bus.inst1_pc,   32'hFFFF_FFFC);
        chk1 ("wrap_inst0_isBr", bus.inst0_isBr, 1'b1);
        chk32("wrap_next_addr",  bus.icache_req_addr, 32'h0);

        // Asynchronous reset mid-WAIT; the old response arrives while in reset.
        bus.icache_req_ready = 1'b1;
        cyc();
        bus.icache_req_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk1 ("arst_req_valid",   bus.icache_req_valid, 1'b0);
        chk32("arst_req_addr",    bus.icache_req_addr,  32'h0);
        chk1 ("arst_inst0_valid", bus.inst0_valid, 1'b0);
        chk32("arst_inst0_pc",    bus.inst0_pc,    32'h0);
        chk32("arst_inst1_word",  bus.inst1_word,  32'h0);
        chk1 ("arst_inst0_isBr",  bus.inst0_isBr,  1'b0);
        cyc();
        bus.icache_resp_valid = 1'b1;
        bus.icache_resp_data  = 64'h1234_5678_9ABC_DEF0;
        cyc();
        bus.icache_resp_valid = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        chk1 ("rel_req_valid",   bus.icache_req_valid, 1'b1);
        chk32("rel_req_addr",    bus.icache_req_addr,  32'hBFC0_0000);
        chk1 ("rel_inst0_valid", bus.inst0_valid, 1'b0);
        fetch(64'h2402_0001_2401_0000);
        chk32("rel_inst0_pc",   bus.inst0_pc,   32'hBFC0_0000);
        chk32("rel_inst1_word", bus.inst1_word, 32'h2402_0001);
        chk32("rel_next_addr",  bus.icache_req_addr, 32'hBFC0_0008);

        repeat (2) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
